// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if
//   Bundles the measured input and the measurement results of clk_period_meter.
//
//   Strobe semantics: O_VALID is a one-cycle, I_CLK-synchronous pulse. It is
//   high in the cycle where O_PERIOD, O_HIGH and O_LOCKED take a new value.
//   There is no back-pressure: a consumer that needs the values must capture
//   them in that cycle. O_PERIOD and O_HIGH then hold until the next pulse.
//
//   Signals:
//     I_SIG      measured signal, asynchronous to I_CLK
//     O_PERIOD   last period, in I_CLK cycles
//     O_HIGH     last high time, in I_CLK cycles
//     O_VALID    update strobe
//     O_LOCKED   two most recent periods equal
//     O_TIMEOUT  no rising edge seen for MAX_CNT cycles
//     dbg_state  FSM state (IDLE=0, MEASURE=1, STALL=2), for observation only
//
//   Modports:
//     master  the meter itself (consumes I_SIG, drives results)
//     slave   the signal source / result consumer
interface clk_period_meter_if #(
    parameter int CNT_W = 16
);
    logic             I_SIG;
    logic [CNT_W-1:0] O_PERIOD;
    logic [CNT_W-1:0] O_HIGH;
    logic             O_VALID;
    logic             O_LOCKED;
    logic             O_TIMEOUT;
    logic [1:0]       dbg_state;

    modport master (
        input  I_SIG,
        output O_PERIOD, O_HIGH, O_VALID, O_LOCKED, O_TIMEOUT, dbg_state
    );

    modport slave (
        output I_SIG,
        input  O_PERIOD, O_HIGH, O_VALID, O_LOCKED, O_TIMEOUT, dbg_state
    );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the period and high time of a slow, asynchronous clock-like
//   signal in I_CLK cycles. One measurement is published per synchronized
//   rising edge of I_SIG (from the second rise on), together with a lock
//   indication (two most recent periods equal) and a timeout flag (no rise
//   for MAX_CNT cycles).
//
//   Parameters:
//     CNT_W    width of the cycle counter and of O_PERIOD / O_HIGH
//     MAX_CNT  count at which a missing edge is declared a timeout
//              (2 <= MAX_CNT <= 2**CNT_W-1; default all ones)
//
//   Ports:
//     I_CLK    system clock, all logic on its rising edge
//     rst_n    asynchronous active-low reset
//     mif      clk_period_meter_if.master (I_SIG in, results out)
module clk_period_meter #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] MAX_CNT = '1
) (
    input  logic                   I_CLK,
    input  logic                   rst_n,
    clk_period_meter_if.master     mif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] STALL   = 2'd2;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_tmp;
    logic [CNT_W-1:0] prev_period;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             valid_q;
    logic             locked_q;
    logic             timeout_q;
    logic [1:0]       state;

    // Two-flop synchronizer; s3 is the previous synchronized value used for
    // edge detection only.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mif.I_SIG;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Cycle counter: restarts at 1 on every rise so that, at the next rise,
    // it holds exactly the number of cycles between the two rises.
    // Saturates instead of wrapping.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= ONE;
        end else if (cnt != MAX_CNT) begin
            cnt <= cnt + ONE;
        end
    end

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            high_tmp    <= '0;
            prev_period <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            // High time is latched at the fall and published at the next rise.
            if (fall && (state != STALL)) begin
                high_tmp <= cnt;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise in the same cycle as cnt==MAX_CNT is a valid
                    // period of exactly MAX_CNT, so it is checked first.
                    if (rise) begin
                        period_q    <= cnt;
                        high_q      <= high_tmp;
                        valid_q     <= 1'b1;
                        locked_q    <= (cnt == prev_period);
                        prev_period <= cnt;
                    end else if (cnt == MAX_CNT) begin
                        state     <= STALL;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                    end
                end
                STALL: begin
                    // The interval ending at this rise spans the outage and is
                    // not a real period: no publish, and clearing prev_period
                    // keeps the first fresh measurement from locking.
                    if (rise) begin
                        state       <= MEASURE;
                        timeout_q   <= 1'b0;
                        prev_period <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mif.O_PERIOD  = period_q;
    assign mif.O_HIGH    = high_q;
    assign mif.O_VALID   = valid_q;
    assign mif.O_LOCKED  = locked_q;
    assign mif.O_TIMEOUT = timeout_q;
    assign mif.dbg_state = state;

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receiving end of the divided-clock interface: takes a slow, asynchronous clock-like signal (e.g. a divider's O_CLK) and measures its period and high time in I_CLK cycles.
- Publishes one measurement per rising edge of the input with a valid strobe, a lock indication and a timeout flag.
- Used as on-chip checker/monitor for clock dividers and as a frequency readout for display logic.

Parameters:
- CNT_W, 16, width of the cycle counter and of O_PERIOD / O_HIGH.
- MAX_CNT, 2**CNT_W-1, count at which a missing edge is declared a timeout (must be >= 2 and <= 2**CNT_W-1).

Ports:
- I_CLK  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- I_SIG  input  1  measured signal, asynchronous to I_CLK.
- O_PERIOD  output  CNT_W  last measured period, in I_CLK cycles between synchronized rising edges.
- O_HIGH  output  CNT_W  last measured high time, in I_CLK cycles from rise to fall within that period.
- O_VALID  output  1  one-cycle pulse when O_PERIOD/O_HIGH update.
- O_LOCKED  output  1  high while the two most recent periods are equal.
- O_TIMEOUT  output  1  high while no rising edge has been seen for MAX_CNT cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): O_PERIOD=0, O_HIGH=0, O_VALID=0, O_LOCKED=0, O_TIMEOUT=0, synchronizer flops=0, cnt=0, state=IDLE.
- Synchronizer: two flops, s1 then s2; s3 holds previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from an I_SIG transition to rise/fall is 2–3 I_CLK cycles; the measured intervals are unaffected.
- Counter cnt:
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at MAX_CNT.
  - With rises at cycles t0 and t0+P, cnt equals P at cycle t0+P.
- On fall in IDLE or MEASURE: high_tmp <= cnt (= H).
- States:
  - IDLE: wait for first rise. On rise go to MEASURE; no O_VALID. Ignores a pending fall before the first rise.
  - MEASURE:
    - On rise: next cycle O_PERIOD <= cnt, O_HIGH <= high_tmp, O_VALID=1 for exactly one cycle, prev_period <= cnt.
    - O_LOCKED <= (cnt == prev_period) on that update.
    - If cnt reaches MAX_CNT with no rise: go to STALL.
  - STALL:
    - O_TIMEOUT=1, O_LOCKED=0; O_PERIOD/O_HIGH hold their last values.
    - On rise: go to MEASURE, O_TIMEOUT <= 0, cnt <= 1, no O_VALID, prev_period <= 0 so the first post-stall measurement cannot lock.
- First valid period after reset: the second rise. O_LOCKED can first assert on the third rise.
- Rise coincident with cnt==MAX_CNT in MEASURE: rise wins. Publish O_PERIOD=MAX_CNT with O_VALID and stay in MEASURE.
- Simultaneous rise and fall cannot occur after synchronization. A glitch narrower than one I_CLK cycle may be missed; this is not an error.
- Constant-high input: no rise after the first, so the block times out.
- Reset mid-measurement aborts the measurement and discards high_tmp; behaviour restarts from IDLE.
- Widths: all counts are unsigned CNT_W bits; no wrap-around (saturation only).

Test Plan:
- I_CLK period 60 ns. I_SIG driven by a divide-by-10 model (5 high/5 low), rst_n released at 10 ns:
  - first O_VALID at the second synchronized rise with O_PERIOD=10, O_HIGH=5, O_LOCKED=0;
  - next O_VALID gives 10/5 with O_LOCKED=1.
- Duty change to 3 high/7 low: O_PERIOD=10, O_HIGH=3; O_LOCKED stays 1.
- Period change from 10 to 12 (6/6): the first 12 measurement drops O_LOCKED to 0, the next one raises it back to 1.
- MAX_CNT=50 and I_SIG held low after lock:
  - O_TIMEOUT=1 exactly 50 cycles after the last counted rise; O_LOCKED=0; O_PERIOD holds 10.
  - Restart the input: no O_VALID on the first rise, O_TIMEOUT clears, then 10/5 on the next rise.
- rst_n pulsed low asynchronously mid-period (between I_CLK edges): all outputs 0 immediately; the next O_VALID comes only after two fresh rises.
- Period exactly MAX_CNT=50 (25/25): O_VALID with O_PERIOD=50 and no O_TIMEOUT assertion.
